fd_spi_master: RTL and testbench

Serial control-port master for the Fine Delay mezzanine. It serialises 24-bit words onto the shared SPI bus (`spi_sclk`, `spi_mosi`, `spi_miso`) and drives one of three chip selects: DAC, PLL or GPIO expander. Words sent to the GPIO expander set the TDC address lines and the trigger/calibration mux. The block sits between the register bank in the core and the `fd_spi_*` FMC pins, and is the direct upstream feeder of the board-side SPI devices.

---
 rtl/fd_spi_master_if.sv | 31 +++
 rtl/fd_spi_master.sv | 156 +++++++++++++++
 tb/tb_fd_spi_master.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fd_spi_master_if.sv
// Control bus between the register bank and the Fine Delay SPI master.
// The register bank drives requests through the master modport.
// The SPI engine serves them through the slave modport.
interface fd_spi_master_if;
    localparam int unsigned c_word_w = 24;

    logic                start_i;
    logic [1:0]          cs_sel_i;
    logic [c_word_w-1:0] data_i;
    logic                busy_o;
    logic                ready_o;
    logic [c_word_w-1:0] data_o;

    modport master (
        output start_i,
        output cs_sel_i,
        output data_i,
        input  busy_o,
        input  ready_o,
        input  data_o
    );

    modport slave (
        input  start_i,
        input  cs_sel_i,
        input  data_i,
        output busy_o,
        output ready_o,
        output data_o
    );
endinterface

// File: rtl/fd_spi_master.sv
// SPI mode-0 master for the Fine Delay control port.
// It shifts one 24-bit word, MSB first, to the DAC, PLL or GPIO expander.
// It captures 24 bits from MISO in the same transfer.
// Every phase lasts g_div system clocks.
module fd_spi_master #(
    parameter int unsigned g_div = 4
) (
    input  logic           clk_sys_i,
    input  logic           rst_i,
    fd_spi_master_if.slave bus,
    output logic           spi_cs_dac_n_o,
    output logic           spi_cs_pll_n_o,
    output logic           spi_cs_gpio_n_o,
    output logic           spi_sclk_o,
    output logic           spi_mosi_o,
    input  logic           spi_miso_i
);
    localparam int unsigned c_word_w = 24;
    localparam int unsigned c_cnt_w  = $clog2(g_div) + 1;
    localparam int unsigned c_bit_w  = 5;
    localparam logic [c_cnt_w-1:0] c_cnt_reload = c_cnt_w'(g_div - 1);
    localparam logic [c_bit_w-1:0] c_last_bit   = c_bit_w'(c_word_w - 1);

    // A half-period shorter than two clocks cannot keep MOSI settled around SCLK.
    if (g_div < 2) begin : g_bad_div
        $error("fd_spi_master: g_div must be at least 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_GAP
    } t_state;

    t_state              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_bit_w-1:0]  r_bit;
    logic [c_word_w-2:0] r_tx;
    logic [c_word_w-1:0] r_rx;
    logic [2:0]          r_cs_n;
    logic                r_sclk;
    logic                r_mosi;
    logic                r_busy;
    logic                r_ready;
    logic [c_word_w-1:0] r_data_out;

    logic w_cnt_done;
    logic w_start_ok;

    assign w_cnt_done = (r_cnt == '0);
    assign w_start_ok = bus.start_i && (bus.cs_sel_i != 2'd3);

    // Transfer sequencer.
    // r_tx holds the bits that follow the one currently on MOSI.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_cs_n     <= 3'b111;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_state <= ST_CS_SETUP;
                        r_cnt   <= c_cnt_reload;
                        r_bit   <= '0;
                        r_tx    <= bus.data_i[c_word_w-2:0];
                        r_rx    <= '0;
                        r_mosi  <= bus.data_i[c_word_w-1];
                        r_busy  <= 1'b1;
                        r_cs_n  <= ~(3'(1) << bus.cs_sel_i);
                    end
                end

                ST_CS_SETUP: begin
                    if (w_cnt_done) begin
                        // The first rising edge samples MISO in the same cycle.
                        r_state <= ST_SHIFT;
                        r_cnt   <= c_cnt_reload;
                        r_sclk  <= 1'b1;
                        r_rx    <= {r_rx[c_word_w-2:0], spi_miso_i};
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end

                ST_SHIFT: begin
                    if (!w_cnt_done) begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end else if (r_sclk) begin
                        // Falling edge: present the next bit while SCLK is low.
                        r_cnt  <= c_cnt_reload;
                        r_sclk <= 1'b0;
                        r_mosi <= r_tx[c_word_w-2];
                        r_tx   <= {r_tx[c_word_w-3:0], 1'b0};
                    end else if (r_bit == c_last_bit) begin
                        r_state <= ST_CS_HOLD;
                        r_cnt   <= c_cnt_reload;
                    end else begin
                        // Rising edge: capture MISO into the receive register.
                        r_cnt  <= c_cnt_reload;
                        r_bit  <= r_bit + c_bit_w'(1);
                        r_sclk <= 1'b1;
                        r_rx   <= {r_rx[c_word_w-2:0], spi_miso_i};
                    end
                end

                ST_CS_HOLD: begin
                    if (w_cnt_done) begin
                        r_state <= ST_GAP;
                        r_cnt   <= c_cnt_reload;
                        r_cs_n  <= 3'b111;
                        r_mosi  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end

                ST_GAP: begin
                    if (w_cnt_done) begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_ready    <= 1'b1;
                        r_data_out <= r_rx;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o      = r_busy;
    assign bus.ready_o     = r_ready;
    assign bus.data_o      = r_data_out;
    assign spi_cs_dac_n_o  = r_cs_n[0];
    assign spi_cs_pll_n_o  = r_cs_n[1];
    assign spi_cs_gpio_n_o = r_cs_n[2];
    assign spi_sclk_o      = r_sclk;
    assign spi_mosi_o      = r_mosi;
endmodule

// File: tb/tb_fd_spi_master.sv
// Directed testbench for fd_spi_master with g_div = 4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fd_spi_master;
    localparam int G   = 4;
    localparam int LAT = 1 + 51 * G;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs_dac_n, cs_pll_n, cs_gpio_n, sclk, mosi, miso;
    logic [1:0] miso_mode;
    logic [2:0] cs_n;

    int n_checks = 0;
    int n_fail   = 0;

    fd_spi_master_if u_if ();

    fd_spi_master #(.g_div(G)) u_dut (
        .clk_sys_i       (clk),
        .rst_i           (rst),
        .bus             (u_if.slave),
        .spi_cs_dac_n_o  (cs_dac_n),
        .spi_cs_pll_n_o  (cs_pll_n),
        .spi_cs_gpio_n_o (cs_gpio_n),
        .spi_sclk_o      (sclk),
        .spi_mosi_o      (mosi),
        .spi_miso_i      (miso)
    );

    always #5 clk = ~clk;

    // MISO source: 0 = loopback from MOSI, 1 = constant low, 2 = constant high.
    assign miso = (miso_mode == 2'd0) ? mosi : (miso_mode == 2'd1) ? 1'b0 : 1'b1;
    assign cs_n = {cs_gpio_n, cs_pll_n, cs_dac_n};

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // 24-bit GPIO expander model: it shifts on SCLK rising edges and latches the word when CS rises.
    logic [23:0] gpio_sr   = '0;
    logic [23:0] gpio_word = '0;
    always @(posedge sclk) if (!cs_gpio_n) gpio_sr <= {gpio_sr[22:0], mosi};
    always @(posedge cs_gpio_n) gpio_word <= gpio_sr;

    // Bus monitor for phase lengths, MOSI stability, the CS gap and the edge count.
    logic p_sclk = 1'b0, p_mosi = 1'b0, p_any = 1'b0;
    int   hi_run = 0, lo_run = 0, rises = 0, gap = 0;
    bit   seen_xfer = 1'b0, mon_en = 1'b0;

    always @(negedge clk) begin
        logic any_cs;
        any_cs = (cs_n != 3'b111);
        if (!any_cs && p_any) begin
            if (mon_en) begin
                check("cs_hold_after_last_fall", lo_run == 2 * G, 32'(lo_run), 32'(2 * G));
                check("sclk_rise_count", rises == 24, 32'(rises), 32'd24);
                check("mosi_idle_after_cs", mosi == 1'b0, 32'(mosi), 32'd0);
            end
            seen_xfer = 1'b1;
            gap = 0;
        end
        if (!any_cs) gap++;
        if (mon_en && any_cs)
            check("single_cs_low", $countones(~cs_n) == 1, 32'(cs_n), 32'd0);
        if (sclk && !p_sclk) begin
            rises++;
            if (mon_en) begin
                check("mosi_stable_at_rise", mosi == p_mosi, 32'(mosi), 32'(p_mosi));
                check("sclk_low_or_setup_len", lo_run == G, 32'(lo_run), 32'(G));
            end
            hi_run = 1;
        end else if (!sclk && p_sclk) begin
            if (mon_en) check("sclk_high_len", hi_run == G, 32'(hi_run), 32'(G));
            lo_run = 1;
        end else if (sclk) begin
            hi_run++;
        end else begin
            lo_run++;
        end
        if (any_cs && !p_any) begin
            if (mon_en && seen_xfer) check("cs_high_gap", gap >= G, 32'(gap), 32'(G));
            lo_run = 1;
            rises  = 0;
        end
        p_sclk = sclk;
        p_mosi = mosi;
        p_any  = any_cs;
    end

    // Issue one start request and check its outcome.
    task automatic run_xfer(input logic [1:0] cs, input logic [23:0] d, input logic [1:0] mode,
                            input bit acc, input logic [23:0] exp_q);
        int k, bad_cs, n_busy, n_ready, n_act;
        logic [2:0] exp_cs_n;
        exp_cs_n  = ~(3'(1) << cs);
        miso_mode = mode;
        @(negedge clk);
        u_if.cs_sel_i = cs;
        u_if.data_i   = d;
        u_if.start_i  = 1'b1;
        @(negedge clk);
        u_if.start_i  = 1'b0;
        u_if.cs_sel_i = ~cs;
        u_if.data_i   = ~d;
        if (acc) begin
            check("busy_at_t1", u_if.busy_o == 1'b1, 32'(u_if.busy_o), 32'd1);
            check("cs_at_t1", cs_n == exp_cs_n, 32'(cs_n), 32'(exp_cs_n));
            check("mosi_msb_at_t1", mosi == d[23], 32'(mosi), 32'(d[23]));
            k = 1;
            bad_cs = 0;
            while (u_if.ready_o !== 1'b1 && k < 2 * LAT) begin
                if (cs_n != 3'b111 && cs_n != exp_cs_n) bad_cs++;
                @(negedge clk);
                k++;
            end
            check("ready_latency", k == LAT, 32'(k), 32'(LAT));
            check("busy_clear_at_ready", u_if.busy_o == 1'b0, 32'(u_if.busy_o), 32'd0);
            check("data_o_at_ready", u_if.data_o == exp_q, 32'(u_if.data_o), 32'(exp_q));
            check("wrong_cs_cycles", bad_cs == 0, 32'(bad_cs), 32'd0);
            if (cs == 2'd2)
                check("gpio_model_word", gpio_word == d, 32'(gpio_word), 32'(d));
            @(negedge clk);
            check("ready_one_cycle", u_if.ready_o == 1'b0, 32'(u_if.ready_o), 32'd0);
            check("data_o_held", u_if.data_o == exp_q, 32'(u_if.data_o), 32'(exp_q));
        end else begin
            n_busy = 0;
            n_ready = 0;
            n_act = 0;
            for (int i = 0; i < 300; i++) begin
                if (u_if.busy_o) n_busy++;
                if (u_if.ready_o) n_ready++;
                if (cs_n != 3'b111 || sclk) n_act++;
                @(negedge clk);
            end
            check("reserved_busy", n_busy == 0, 32'(n_busy), 32'd0);
            check("reserved_ready", n_ready == 0, 32'(n_ready), 32'd0);
            check("reserved_bus_activity", n_act == 0, 32'(n_act), 32'd0);
            check("reserved_data_o_held", u_if.data_o == exp_q, 32'(u_if.data_o), 32'(exp_q));
        end
    endtask

    typedef struct {
        logic [1:0]  cs;
        logic [23:0] data;
        logic [1:0]  mode;
        bit          acc;
        logic [23:0] exp_q;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n_ready, first_ready, pll_low, n_busy;

        vecs[0] = '{cs: 2'd2, data: 24'h000005, mode: 2'd0, acc: 1'b1, exp_q: 24'h000005};
        vecs[1] = '{cs: 2'd0, data: 24'hA5C3F0, mode: 2'd0, acc: 1'b1, exp_q: 24'hA5C3F0};
        vecs[2] = '{cs: 2'd3, data: 24'hABCDEF, mode: 2'd0, acc: 1'b0, exp_q: 24'hA5C3F0};
        vecs[3] = '{cs: 2'd1, data: 24'h123456, mode: 2'd1, acc: 1'b1, exp_q: 24'h000000};
        vecs[4] = '{cs: 2'd0, data: 24'h800001, mode: 2'd2, acc: 1'b1, exp_q: 24'hFFFFFF};
        vecs[5] = '{cs: 2'd1, data: 24'h5A5A5A, mode: 2'd0, acc: 1'b1, exp_q: 24'h5A5A5A};

        rst = 1'b1;
        miso_mode = 2'd0;
        u_if.start_i  = 1'b0;
        u_if.cs_sel_i = 2'd0;
        u_if.data_i   = '0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n == 3'b111, 32'(cs_n), 32'h7);
        check("rst_sclk", sclk == 1'b0, 32'(sclk), 32'd0);
        check("rst_mosi", mosi == 1'b0, 32'(mosi), 32'd0);
        check("rst_busy", u_if.busy_o == 1'b0, 32'(u_if.busy_o), 32'd0);
        check("rst_ready", u_if.ready_o == 1'b0, 32'(u_if.ready_o), 32'd0);
        check("rst_data_o", u_if.data_o == 24'h0, 32'(u_if.data_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        for (int i = 0; i < 6; i++)
            run_xfer(vecs[i].cs, vecs[i].data, vecs[i].mode, vecs[i].acc, vecs[i].exp_q);

        // A start while busy must be ignored, along with changes to select and data.
        miso_mode = 2'd0;
        @(negedge clk);
        u_if.cs_sel_i = 2'd0;
        u_if.data_i   = 24'h3C0FF0;
        u_if.start_i  = 1'b1;
        @(negedge clk);
        u_if.start_i = 1'b0;
        k = 1;
        n_ready = 0;
        first_ready = 0;
        pll_low = 0;
        while (k < 420) begin
            if (k == 50) begin
                u_if.start_i  = 1'b1;
                u_if.cs_sel_i = 2'd1;
                u_if.data_i   = 24'hFFFFFF;
            end else if (k == 51) begin
                u_if.start_i = 1'b0;
            end
            if (u_if.ready_o) begin
                n_ready++;
                if (first_ready == 0) first_ready = k;
            end
            if (!cs_pll_n) pll_low++;
            @(negedge clk);
            k++;
        end
        check("busy_start_latency", first_ready == LAT, 32'(first_ready), 32'(LAT));
        check("busy_start_ready_count", n_ready == 1, 32'(n_ready), 32'd1);
        check("busy_start_pll_cs", pll_low == 0, 32'(pll_low), 32'd0);
        check("busy_start_data_o", u_if.data_o == 24'h3C0FF0, 32'(u_if.data_o), 32'h3C0FF0);

        // A one-cycle reset 100 cycles into a transfer aborts it without a completion pulse.
        @(negedge clk);
        u_if.cs_sel_i = 2'd2;
        u_if.data_i   = 24'h0000AA;
        u_if.start_i  = 1'b1;
        @(negedge clk);
        u_if.start_i = 1'b0;
        k = 1;
        while (k < 100) begin
            @(negedge clk);
            k++;
        end
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_cs_n", cs_n == 3'b111, 32'(cs_n), 32'h7);
        check("midrst_sclk", sclk == 1'b0, 32'(sclk), 32'd0);
        check("midrst_mosi", mosi == 1'b0, 32'(mosi), 32'd0);
        check("midrst_busy", u_if.busy_o == 1'b0, 32'(u_if.busy_o), 32'd0);
        check("midrst_ready", u_if.ready_o == 1'b0, 32'(u_if.ready_o), 32'd0);
        check("midrst_data_o", u_if.data_o == 24'h0, 32'(u_if.data_o), 32'd0);
        n_ready = 0;
        n_busy = 0;
        for (int i = 0; i < 300; i++) begin
            if (u_if.ready_o) n_ready++;
            if (u_if.busy_o) n_busy++;
            @(negedge clk);
        end
        check("midrst_no_ready", n_ready == 0, 32'(n_ready), 32'd0);
        check("midrst_no_busy", n_busy == 0, 32'(n_busy), 32'd0);
        mon_en = 1'b1;
        run_xfer(2'd2, 24'h0000AA, 2'd0, 1'b1, 24'h0000AA);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
